// File: rtl/maple_frame_decoder.sv
// Maple line deserialiser: collects SDCKA/SDCKB phase-alternating bits into words,
// queues them in a small output FIFO and reports per-frame status.
module maple_frame_decoder #(
  parameter int WORD_BYTES = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    sdcka_data,
  input  logic                    sdcka_negedge,
  input  logic                    sdckb_data,
  input  logic                    sdckb_negedge,
  output logic [8*WORD_BYTES-1:0] out_data,
  output logic [2:0]              out_bytes,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    frame_done,
  output logic [CNT_W-1:0]        frame_words,
  output logic                    frame_overflow,
  output logic                    frame_misalign,
  output logic [2:0]              state_dbg
);

  localparam int W    = 8 * WORD_BYTES;
  localparam int BC_W = $clog2(W);
  localparam int SW   = BC_W + 1;
  localparam int AW   = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PHASE1 = 3'd1,
    PHASE2 = 3'd2,
    FLUSH  = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Output handshake: the head entry transfers on any rising clk edge where
  // out_valid & out_ready are both high; out_data/out_bytes hold until then.

  state_t            state;
  logic [W-1:0]      shift_reg;
  logic [BC_W-1:0]   bit_cnt;
  logic              pend_valid;
  logic [W-1:0]      pend_word;
  logic [2:0]        pend_bytes;

  logic [W-1:0]      mem_data [FIFO_DEPTH];
  logic [2:0]        mem_bytes [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;

  logic              sample_a;
  logic              sample_b;
  logic              sample;
  logic              sample_bit;
  logic              word_last;
  logic              res_aligned;
  logic [W-1:0]      flush_word;
  logic [2:0]        flush_bytes;
  logic              push_req;
  logic [W-1:0]      push_word;
  logic [2:0]        push_bytes;
  logic              full;
  logic              pop;
  logic              push_ok;

  assign state_dbg = state;

  // An SDCKA strobe in IDLE with enable high already counts as the first PHASE1 bit.
  assign sample_a   = enable && sdcka_negedge && (state == IDLE || state == PHASE1);
  assign sample_b   = enable && sdckb_negedge && (state == PHASE2);
  assign sample     = sample_a || sample_b;
  assign sample_bit = sample_a ? sdckb_data : sdcka_data;
  assign word_last  = sample && (bit_cnt == BC_W'(W - 1));

  assign res_aligned = (state == FLUSH) && (bit_cnt[2:0] == 3'd0) && (bit_cnt != '0);
  assign flush_word  = shift_reg << (SW'(W) - SW'(bit_cnt));
  assign flush_bytes = 3'(bit_cnt >> 3);

  assign push_req   = pend_valid || res_aligned;
  assign push_word  = res_aligned ? flush_word : pend_word;
  assign push_bytes = res_aligned ? flush_bytes : pend_bytes;

  assign out_valid = (count != '0);
  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign pop       = out_valid && out_ready;
  assign push_ok   = push_req && (!full || pop);
  assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
  assign out_bytes = out_valid ? mem_bytes[rd_ptr] : 3'd0;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_data[wr_ptr]  <= push_word;
      mem_bytes[wr_ptr] <= push_bytes;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (!push_ok && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      shift_reg      <= '0;
      bit_cnt        <= '0;
      pend_valid     <= 1'b0;
      pend_word      <= '0;
      pend_bytes     <= 3'd0;
      frame_done     <= 1'b0;
      frame_words    <= '0;
      frame_overflow <= 1'b0;
      frame_misalign <= 1'b0;
    end else begin
      pend_valid <= word_last;
      if (word_last) begin
        pend_word  <= {shift_reg[W-2:0], sample_bit};
        pend_bytes <= 3'(WORD_BYTES);
      end
      frame_done <= (state == FLUSH);

      if (sample) begin
        shift_reg <= {shift_reg[W-2:0], sample_bit};
        bit_cnt   <= word_last ? '0 : bit_cnt + 1'b1;
      end

      // Dropped words still count towards the frame total.
      if (push_req) begin
        if (frame_words != '1) frame_words <= frame_words + 1'b1;
        if (!push_ok) frame_overflow <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (enable) begin
            frame_words    <= '0;
            frame_overflow <= 1'b0;
            frame_misalign <= 1'b0;
            state          <= sample ? PHASE2 : PHASE1;
          end
        end
        PHASE1: begin
          if (!enable)     state <= FLUSH;
          else if (sample) state <= PHASE2;
        end
        PHASE2: begin
          if (!enable)     state <= FLUSH;
          else if (sample) state <= PHASE1;
        end
        FLUSH: begin
          if (bit_cnt[2:0] != 3'd0) frame_misalign <= 1'b1;
          shift_reg <= '0;
          bit_cnt   <= '0;
          state     <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maple_frame_decoder.sv
// Scoreboard bench for maple_frame_decoder (WORD_BYTES=4, FIFO_DEPTH=4, CNT_W=8).
module tb_maple_frame_decoder;

  localparam int WB    = 4;
  localparam int DEPTH = 4;
  localparam int W     = 8 * WB;

  logic          clk;
  logic          reset;
  logic          enable;
  logic          sdcka_data;
  logic          sdcka_negedge;
  logic          sdckb_data;
  logic          sdckb_negedge;
  logic [W-1:0]  out_data;
  logic [2:0]    out_bytes;
  logic          out_valid;
  logic          out_ready;
  logic          frame_done;
  logic [7:0]    frame_words;
  logic          frame_overflow;
  logic          frame_misalign;
  logic [2:0]    state_dbg;

  maple_frame_decoder #(.WORD_BYTES(WB), .FIFO_DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .sdcka_data     (sdcka_data),
    .sdcka_negedge  (sdcka_negedge),
    .sdckb_data     (sdckb_data),
    .sdckb_negedge  (sdckb_negedge),
    .out_data       (out_data),
    .out_bytes      (out_bytes),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .frame_done     (frame_done),
    .frame_words    (frame_words),
    .frame_overflow (frame_overflow),
    .frame_misalign (frame_misalign),
    .state_dbg      (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [W+2:0] exp_q[$];   // {bytes, data}
  logic [9:0]   frame_q[$]; // {words, overflow, misalign}
  bit           bq[$];
  int           ph;
  int           last_words;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: pops on each accepted word and each frame_done pulse
  always @(negedge clk) begin
    if (reset) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check_eq("unexpected_word", {out_bytes, out_data}, '0);
        else check_eq("word", {out_bytes, out_data}, exp_q.pop_front());
      end else if (out_valid && exp_q.size() != 0) begin
        check_eq("hold", {out_bytes, out_data}, exp_q[0]);
      end
      if (frame_done) begin
        if (frame_q.size() == 0) check_eq("unexpected_frame_done", 1, 0);
        else check_eq("frame_status", {frame_words, frame_overflow, frame_misalign}, frame_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic send_bit(input bit b);
    if (ph == 0) begin
      sdckb_data = b; sdcka_negedge = 1'b1;
    end else begin
      sdcka_data = b; sdckb_negedge = 1'b1;
    end
    @(posedge clk); #1;
    sdcka_negedge = 1'b0;
    sdckb_negedge = 1'b0;
    ph ^= 1;
  endtask

  task automatic wrong_strobe();
    if (ph == 0) begin
      sdcka_data = 1'($urandom_range(0, 1)); sdckb_negedge = 1'b1;
    end else begin
      sdckb_data = 1'($urandom_range(0, 1)); sdcka_negedge = 1'b1;
    end
    @(posedge clk); #1;
    sdcka_negedge = 1'b0;
    sdckb_negedge = 1'b0;
  endtask

  task automatic load_hex(input logic [63:0] v, input int n);
    bq.delete();
    for (int i = 0; i < n; i++) bq.push_back(v[n-1-i]);
  endtask

  task automatic load_rand(input int n);
    bq.delete();
    for (int i = 0; i < n; i++) bq.push_back(1'($urandom_range(0, 1)));
  endtask

  // Drives bq as one frame; cap = words the FIFO can absorb.
  task automatic run_frame(input int cap, input bit same_cycle, input bit check_lat);
    int n, nf, r, total, pushed;
    logic [W-1:0] word;
    n = bq.size(); nf = n / W; r = n % W;
    total = 0; pushed = 0;
    for (int w = 0; w < nf; w++) begin
      word = '0;
      for (int b = 0; b < W; b++) word = {word[W-2:0], 1'(bq[w*W+b])};
      if (pushed < cap) begin exp_q.push_back({3'(WB), word}); pushed++; end
      total++;
    end
    if (r > 0 && r % 8 == 0) begin
      word = '0;
      for (int b = 0; b < r; b++) word = {word[W-2:0], 1'(bq[nf*W+b])};
      word = word << (W - r);
      if (pushed < cap) begin exp_q.push_back({3'(r / 8), word}); pushed++; end
      total++;
    end
    frame_q.push_back({8'(total), total > cap, (r % 8) != 0});
    last_words = total;

    ph = 0;
    enable = 1'b1;
    if (!same_cycle) begin @(posedge clk); #1; end
    for (int i = 0; i < n; i++) begin
      if (i > 0 && $urandom_range(0, 3) == 0) wrong_strobe();
      send_bit(bq[i]);
    end
    enable = 1'b0;
    if (check_lat) begin
      check_eq("lat_push_cycle", out_valid, 0);
      @(posedge clk); #1;
      check_eq("lat_valid", out_valid, 1);
    end
    for (int i = 0; i < 20 && frame_q.size() != 0; i++) @(posedge clk);
    #1;
    check_eq("frame_done_seen", frame_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("frame_words_held", frame_words, 8'(last_words));
    check_eq("back_to_idle", state_dbg, 0);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check_eq("drain_done", exp_q.size(), 0);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; out_ready = 1'b1; ph = 0;
    sdcka_data = 1'b0; sdckb_data = 1'b0; sdcka_negedge = 1'b0; sdckb_negedge = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_data", out_data, 0);
    check_eq("rst_done", frame_done, 0);
    check_eq("rst_words", frame_words, 0);
    check_eq("rst_flags", {frame_overflow, frame_misalign}, 0);
    check_eq("rst_state", state_dbg, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // single full word, with push/valid latency
    load_hex(64'hDEADBEEF, 32);
    run_frame(1000, 1'b0, 1'b1);
    wait_drain();

    // 40 bits: one full word plus one padded byte; first bit rides on the enable cycle
    load_hex(64'h1122334455, 40);
    run_frame(1000, 1'b1, 1'b0);
    wait_drain();

    // 16-bit residue only
    load_hex(64'hA5C3, 16);
    run_frame(1000, 1'b1, 1'b0);
    wait_drain();

    // 13 bits: misaligned, residue discarded
    load_hex(64'h1B35, 13);
    run_frame(1000, 1'b0, 1'b0);
    wait_drain();

    // overflow: six words into a stalled four-entry FIFO, then drain in order
    out_ready = 1'b0;
    load_rand(6 * W);
    run_frame(DEPTH, 1'b0, 1'b0);
    check_eq("ovf_flag", frame_overflow, 1);
    out_ready = 1'b1;
    wait_drain();

    // FIFO contents survive into the next frame
    out_ready = 1'b0;
    load_rand(W);
    run_frame(1000, 1'b0, 1'b0);
    load_rand(W + 8);
    run_frame(1000, 1'b0, 1'b0);
    out_ready = 1'b1;
    wait_drain();

    // random frames
    for (int k = 0; k < 4; k++) begin
      int n;
      n = 8 * $urandom_range(1, 10);
      if ($urandom_range(0, 2) == 0) n += $urandom_range(1, 7);
      load_rand(n);
      run_frame(1000, 1'($urandom_range(0, 1)), 1'b0);
      wait_drain();
    end

    // reset mid-word with two words queued
    out_ready = 1'b0;
    ph = 0;
    enable = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 2 * W + 10; i++) send_bit(1'($urandom_range(0, 1)));
    repeat (3) @(posedge clk);
    #1;
    check_eq("mid_valid_before", out_valid, 1);
    reset = 1'b0;
    enable = 1'b0;
    @(posedge clk); #1;
    check_eq("mid_valid_after", out_valid, 0);
    check_eq("mid_state", state_dbg, 0);
    check_eq("mid_done", frame_done, 0);
    check_eq("mid_words", frame_words, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("mid_empty", out_valid, 0);
    load_hex(64'hCAFEF00D, 32);
    run_frame(1000, 1'b0, 1'b0);
    check_eq("clean_flags", {frame_overflow, frame_misalign}, 0);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
